// File: rtl/packer_arbiter_pkg.sv
// Shared constants, lane index type and FSM encoding for the byte-lane packer/arbiter.
package packer_arbiter_pkg;

    localparam int unsigned NUM_LANES      = 4;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned LANE_W         = 2;
    localparam int unsigned CNT_W          = 2;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;
    localparam int unsigned BUS_W          = NUM_LANES * BYTE_W;

    typedef logic [LANE_W-1:0] lane_t;

    typedef enum logic {
        IDLE = 1'b0,
        PACK = 1'b1
    } state_t;

endpackage

// File: rtl/packer_arbiter_rr_select.sv
// Combinational round-robin picker: first requesting lane after 'last', wrapping.
module rr_select
    import packer_arbiter_pkg::*;
(
    input  logic [NUM_LANES-1:0] req,
    input  lane_t                last,
    output logic [NUM_LANES-1:0] gnt,
    output lane_t                idx,
    output logic                 any
);

    lane_t cand;
    logic  found;

    // Scan last+1 .. last+4; the 2-bit add provides the mod-4 wrap.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        cand  = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= NUM_LANES; i++) begin
            cand = last + LANE_W'(i);
            if (!found && req[cand]) begin
                found     = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/packer_arbiter.sv
// Grants one byte lane round-robin and packs four of its bytes, MSB first, into a 32-bit word.
module packer_arbiter
    import packer_arbiter_pkg::*;
(
    input  logic                 clk_4f,
    input  logic                 reset,
    input  logic [NUM_LANES-1:0] req_in,
    input  logic [NUM_LANES-1:0] valid_in,
    input  logic [BUS_W-1:0]     data_in,
    output logic [NUM_LANES-1:0] gnt_out,
    output logic [WORD_W-1:0]    data_out,
    output logic                 valid_out,
    output lane_t                lane_out,
    output logic                 err_out
);

    state_t               state, state_d;
    logic [CNT_W-1:0]     byte_cnt, cnt_d;
    lane_t                last_lane, last_d;
    lane_t                cur_lane, cur_d;
    logic [NUM_LANES-1:0] gnt_d;
    logic [WORD_W-1:0]    data_d;
    logic                 valid_d;
    lane_t                lane_d;
    logic                 err_d;

    logic [NUM_LANES-1:0] rr_gnt;
    lane_t                rr_idx;
    logic                 rr_any;

    rr_select u_rr_select (
        .req  (req_in),
        .last (last_lane),
        .gnt  (rr_gnt),
        .idx  (rr_idx),
        .any  (rr_any)
    );

    // Byte offsets: granted lane's byte in data_in, and slot k counted down from [31:24].
    logic [4:0] lane_pos;
    logic [4:0] word_pos;
    assign lane_pos = {cur_lane, 3'b000};
    assign word_pos = {~byte_cnt, 3'b000};

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state     <= IDLE;
            byte_cnt  <= '0;
            last_lane <= LANE_W'(NUM_LANES - 1);
            cur_lane  <= '0;
            gnt_out   <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            lane_out  <= '0;
            err_out   <= 1'b0;
        end else begin
            state     <= state_d;
            byte_cnt  <= cnt_d;
            last_lane <= last_d;
            cur_lane  <= cur_d;
            gnt_out   <= gnt_d;
            data_out  <= data_d;
            valid_out <= valid_d;
            lane_out  <= lane_d;
            err_out   <= err_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = byte_cnt;
        last_d  = last_lane;
        cur_d   = cur_lane;
        gnt_d   = gnt_out;
        data_d  = data_out;
        valid_d = 1'b0;
        lane_d  = lane_out;
        err_d   = 1'b0;
        unique case (state)
            IDLE: begin
                gnt_d = '0;
                if (rr_any) begin
                    gnt_d   = rr_gnt;
                    cur_d   = rr_idx;
                    cnt_d   = '0;
                    state_d = PACK;
                end
            end
            PACK: begin
                if (valid_in[cur_lane]) begin
                    data_d[word_pos +: BYTE_W] = data_in[lane_pos +: BYTE_W];
                    cnt_d = byte_cnt + CNT_W'(1);
                    if (byte_cnt == CNT_W'(BYTES_PER_WORD - 1)) begin
                        valid_d = 1'b1;
                        lane_d  = cur_lane;
                        gnt_d   = '0;
                        last_d  = cur_lane;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end else if (byte_cnt == '0) begin
                    // Nothing captured yet: withdrawal leaves the rotation untouched.
                    if (!req_in[cur_lane]) begin
                        gnt_d   = '0;
                        state_d = IDLE;
                    end
                end else begin
                    err_d   = 1'b1;
                    data_d  = '0;
                    cnt_d   = '0;
                    gnt_d   = '0;
                    last_d  = cur_lane;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/packer_arbiter.md
PACKER_ARBITER -- requirements
Module: packer_arbiter

Interface
REQ-001 The block SHALL use parameters NUM_LANES = 4 (requesting byte lanes) and BYTES_PER_WORD = 4 (bytes packed per 32-bit word).
REQ-002 The block SHALL have the following ports.
- clk_4f  in  1  single clock, byte rate; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_in  in  4  per-lane request for one 32-bit word.
- valid_in  in  4  per-lane byte valid.
- data_in  in  32  lane i byte at [8i+7:8i].
- gnt_out  out  4  one-hot grant, registered.
- data_out  out  32  packed word; first accepted byte at [31:24].
- valid_out  out  1  one-cycle pulse; data_out holds a complete word.
- lane_out  out  2  lane index of the word on data_out.
- err_out  out  1  one-cycle pulse; a partial word was aborted.

Function
REQ-003 The FSM SHALL have exactly two states, IDLE and PACK.
REQ-004 In IDLE with any req_in bit set, the FSM SHALL grant one lane using round-robin order starting at (last_lane+1) mod 4.
- The grant SHALL set gnt_out one-hot at that edge and move to PACK with byte_cnt = 0.
REQ-005 In IDLE with req_in = 0, the FSM SHALL hold gnt_out = 0 and remain in IDLE.
REQ-006 A byte SHALL be accepted on any edge in PACK where valid_in[g] = 1 for the granted lane g.
- Byte k (k = byte_cnt) SHALL be written to data_out[31-8k:24-8k].
- byte_cnt SHALL then increment.
REQ-007 On the edge that accepts byte 3, the block SHALL:
- assert valid_out = 1 and lane_out = g for the following cycle;
- clear gnt_out;
- set last_lane = g;
- return to IDLE.
REQ-008 valid_out SHALL be 0 in every other cycle.
REQ-009 data_out SHALL hold its value until the next byte acceptance.
REQ-010 Timing SHALL be as follows.
- Minimum latency from grant edge to valid_out is 4 edges.
- One IDLE cycle separates consecutive words, giving peak throughput of 4 bytes per 5 cycles.
REQ-011 In PACK with byte_cnt = 0, valid_in[g] = 0 and req_in[g] = 1, the block SHALL wait in PACK with no timeout.
REQ-012 In PACK with byte_cnt = 0 and req_in[g] = 0, the block SHALL clear gnt_out and return to IDLE, and last_lane SHALL be unchanged.
REQ-013 In PACK with byte_cnt > 0 and valid_in[g] = 0, the block SHALL abort the word.
- Pulse err_out for one cycle.
- Clear data_out to 0 and byte_cnt to 0.
- Clear gnt_out, set last_lane = g, and return to IDLE.
- Do not assert valid_out.
REQ-014 The block SHALL ignore valid_in and data_in of non-granted lanes.
REQ-015 The block SHALL ignore req_in changes of other lanes during PACK; a new request is only seen at the next IDLE arbitration.
REQ-016 byte_cnt SHALL be 2 bits and SHALL never wrap while in PACK, because the REQ-007 exit at byte 3 precedes any wrap.
REQ-017 At most one bit of gnt_out SHALL be set at any time.

Reset
REQ-018 With reset = 1 at a rising edge, the block SHALL set:
- state = IDLE, gnt_out = 0, data_out = 0, valid_out = 0;
- lane_out = 0, err_out = 0, byte_cnt = 0, last_lane = 3.
REQ-019 Reset SHALL take priority over all other behaviour, including mid-word.
- A partial word is discarded without an err_out pulse.
REQ-020 After reset, lane 0 SHALL have the highest priority.

Structure
REQ-021 A shared package SHALL hold:
- NUM_LANES and BYTES_PER_WORD;
- the state encodings IDLE = 0 and PACK = 1;
- the lane-index width (2).
REQ-022 The round-robin selection SHALL be a combinational sub-module, rr_select.
- Inputs: req 4b, last 2b.
- Outputs: gnt one-hot 4b, idx 2b, any 1b.
REQ-023 Byte capture, byte_cnt and the FSM SHALL reside in packer_arbiter.

Verification
REQ-024 Single lane: after reset, req_in = 0001 with valid_in[0] = 1 and bytes 0xAA, 0xBB, 0xCC, 0xDD. Required response: gnt_out = 0001, then valid_out for 1 cycle with data_out = 0xAABBCCDD and lane_out = 0, 4 edges after the grant.
REQ-025 Fairness: req_in = 1111 held with all lanes streaming. Required response: words granted in lane order 0, 1, 2, 3, 0, and valid_out asserts every 5 cycles.
REQ-026 Abort: lane 2 granted and delivers 0x11 and 0x22, then valid_in[2] = 0. Required response: err_out pulses for 1 cycle, data_out = 0, no valid_out, and the next grant goes to lane 3 if it requests.
REQ-027 Withdrawn request: lane 1 granted, then req_in[1] = 0 before any byte. Required response: gnt_out = 0 on the next edge, no err_out, and lane 1 remains first in priority.
REQ-028 Reset mid-word: reset asserted after 2 bytes of lane 0. Required response: all outputs 0 on the next edge, and the subsequent grant with req_in = 0011 goes to lane 0.
REQ-029 Stall before first byte: lane 3 granted with valid_in[3] = 0 for 10 cycles, then 4 bytes 0x01 to 0x04. Required response: data_out = 0x01020304 and gnt_out stays 1000 throughout the stall.
